// File: rtl/wm_mem_ctrl.sv
// Watermark buffer sequencer: preloads one frame of watermark words from the upstream
// stream, then grants DOP-bit symbol reads to the embedder and pulses done/clear at frame end.
module wm_mem_ctrl #(
    parameter int WM_BAND_WIDTH = 128,
    parameter int DOP           = 4,
    parameter int WM_CNT        = 313,
    parameter int FIFO_DEPTH    = 512
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_start,
    input  logic                     i_abort,
    input  logic                     i_wm_tvalid,
    input  logic [WM_BAND_WIDTH-1:0] i_wm_tdata,
    output logic                     o_wm_tready,
    output logic [WM_BAND_WIDTH-1:0] o_w_data,
    output logic                     o_wea,
    input  logic                     i_wm_cnt_last,
    input  logic                     i_pix_req,
    output logic                     o_pix_ready,
    output logic                     o_rea,
    output logic                     o_done,
    output logic                     o_busy,
    output logic                     o_err
);

    localparam int TOTAL = WM_CNT * WM_BAND_WIDTH / DOP;
    localparam int WCW   = (WM_CNT > 1) ? $clog2(WM_CNT) : 1;
    localparam int SCW   = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam logic [WCW-1:0] WORD_LAST = WCW'(WM_CNT - 1);
    localparam logic [SCW-1:0] SYM_LAST  = SCW'(TOTAL - 1);

    generate
        if (WM_CNT > FIFO_DEPTH) begin : g_depth_check
            $error("wm_mem_ctrl: WM_CNT exceeds FIFO_DEPTH");
        end
        if ((WM_BAND_WIDTH % DOP) != 0) begin : g_width_check
            $error("wm_mem_ctrl: WM_BAND_WIDTH must be a multiple of DOP");
        end
    endgenerate

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_EMBED, ST_DONE} state_t;

    state_t         state_reg, state_next;
    logic [WCW-1:0] word_cnt_reg, word_cnt_next;
    logic [SCW-1:0] sym_cnt_reg, sym_cnt_next;
    logic           err_reg, err_next;
    logic           word_last_hit;
    logic           sym_last_hit;

    // Abort masks the handshakes in the same cycle so no write/read slips through.
    assign o_wm_tready   = (state_reg == ST_LOAD) && !i_abort;
    assign o_wea         = i_wm_tvalid && o_wm_tready;
    assign o_w_data      = i_wm_tdata;
    assign o_pix_ready   = (state_reg == ST_EMBED) && !i_abort;
    assign o_rea         = i_pix_req && o_pix_ready;
    assign o_done        = (state_reg == ST_DONE);
    assign o_busy        = (state_reg != ST_IDLE);
    assign o_err         = err_reg;

    assign word_last_hit = o_wea && (word_cnt_reg == WORD_LAST);
    assign sym_last_hit  = o_rea && (sym_cnt_reg == SYM_LAST);

    always_comb begin
        state_next    = state_reg;
        word_cnt_next = word_cnt_reg;
        sym_cnt_next  = sym_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (i_start) begin
                    state_next    = ST_LOAD;
                    word_cnt_next = '0;
                    sym_cnt_next  = '0;
                end
            end
            ST_LOAD: begin
                if (i_abort) begin
                    state_next = ST_DONE;
                end else if (o_wea) begin
                    // Counter returns to zero on the terminal word so it never wraps past it.
                    word_cnt_next = word_last_hit ? '0 : word_cnt_reg + WCW'(1);
                    if (word_last_hit) begin
                        state_next   = ST_EMBED;
                        sym_cnt_next = '0;
                    end
                end
            end
            ST_EMBED: begin
                if (i_abort) begin
                    state_next = ST_DONE;
                end else if (o_rea) begin
                    sym_cnt_next = sym_last_hit ? '0 : sym_cnt_reg + SCW'(1);
                    if (sym_last_hit) begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_next    = ST_IDLE;
                word_cnt_next = '0;
                sym_cnt_next  = '0;
            end
            default: begin
                state_next    = ST_IDLE;
                word_cnt_next = '0;
                sym_cnt_next  = '0;
            end
        endcase
    end

    // Sticky protocol error: buffer last-flag mismatch, underrun request, or start while busy.
    always_comb begin
        err_next = err_reg
                 | (i_wm_cnt_last != word_last_hit)
                 | (i_pix_req && ((state_reg == ST_IDLE) || (state_reg == ST_LOAD)))
                 | (i_start && o_busy);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            word_cnt_reg <= '0;
            sym_cnt_reg  <= '0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            word_cnt_reg <= word_cnt_next;
            sym_cnt_reg  <= sym_cnt_next;
            err_reg      <= err_next;
        end
    end

endmodule

// File: tb/tb_wm_mem_ctrl.sv
// Directed bench for wm_mem_ctrl with WM_CNT=3, DOP=4, WM_BAND_WIDTH=16 (12 symbols per frame).
module tb_wm_mem_ctrl;

    localparam int W = 16;

    logic         clk;
    logic         rst;
    logic         i_start;
    logic         i_abort;
    logic         i_wm_tvalid;
    logic [W-1:0] i_wm_tdata;
    logic         o_wm_tready;
    logic [W-1:0] o_w_data;
    logic         o_wea;
    logic         i_wm_cnt_last;
    logic         i_pix_req;
    logic         o_pix_ready;
    logic         o_rea;
    logic         o_done;
    logic         o_busy;
    logic         o_err;

    int total = 0;
    int bad   = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    int done_cnt = 0;
    logic [W-1:0] wq[$];

    wm_mem_ctrl #(
        .WM_BAND_WIDTH(16),
        .DOP(4),
        .WM_CNT(3),
        .FIFO_DEPTH(512)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_start(i_start),
        .i_abort(i_abort),
        .i_wm_tvalid(i_wm_tvalid),
        .i_wm_tdata(i_wm_tdata),
        .o_wm_tready(o_wm_tready),
        .o_w_data(o_w_data),
        .o_wea(o_wea),
        .i_wm_cnt_last(i_wm_cnt_last),
        .i_pix_req(i_pix_req),
        .o_pix_ready(o_pix_ready),
        .o_rea(o_rea),
        .o_done(o_done),
        .o_busy(o_busy),
        .o_err(o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sample outputs on the falling edge, score writes against the queue, then step past posedge.
    task automatic tick();
        @(negedge clk);
        if (o_wea) begin
            chk("sb_nonempty", 32'(wq.size() != 0), 1);
            if (wq.size() != 0) chk("sb_w_data", 32'(o_w_data), 32'(wq.pop_front()));
            wr_cnt++;
        end
        if (o_rea)  rd_cnt++;
        if (o_done) done_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [W-1:0] d, input logic last);
        i_wm_tvalid   = 1'b1;
        i_wm_tdata    = d;
        i_wm_cnt_last = last;
        wq.push_back(d);
        #1;
        chk("load_wea", 32'(o_wea), 1);
        tick();
        i_wm_tvalid   = 1'b0;
        i_wm_cnt_last = 1'b0;
    endtask

    task automatic start_frame();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_err", 32'(o_err), 0);
        chk("rst_busy", 32'(o_busy), 0);
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic normal_frame();
        int w0, r0, d0;
        w0 = wr_cnt; r0 = rd_cnt; d0 = done_cnt;
        i_start = 1'b1;
        #1;
        chk("nf_idle_busy", 32'(o_busy), 0);
        tick();
        i_start = 1'b0;
        #1;
        chk("nf_tready", 32'(o_wm_tready), 1);
        chk("nf_busy", 32'(o_busy), 1);
        for (int i = 0; i < 3; i++) load_word(W'($urandom), i == 2);
        #1;
        chk("nf_pix_ready", 32'(o_pix_ready), 1);
        chk("nf_tready_off", 32'(o_wm_tready), 0);
        for (int i = 0; i < 12; i++) begin
            i_pix_req = 1'b1;
            #1;
            chk("nf_rea", 32'(o_rea), 1);
            tick();
        end
        i_pix_req = 1'b0;
        #1;
        chk("nf_done", 32'(o_done), 1);
        tick();
        chk("nf_done_off", 32'(o_done), 0);
        chk("nf_busy_off", 32'(o_busy), 0);
        chk("nf_writes", 32'(wr_cnt - w0), 3);
        chk("nf_reads", 32'(rd_cnt - r0), 12);
        chk("nf_done_cnt", 32'(done_cnt - d0), 1);
        chk("nf_err", 32'(o_err), 0);
    endtask

    initial begin
        int w0, r0, d0, nw, ns;
        rst = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_wm_tvalid = 1'b0;
        i_wm_tdata = '0; i_wm_cnt_last = 1'b0; i_pix_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        i_wm_tdata = 16'h1234;
        #1;
        chk("rst_busy0", 32'(o_busy), 0);
        chk("rst_done0", 32'(o_done), 0);
        chk("rst_tready0", 32'(o_wm_tready), 0);
        chk("rst_pix_ready0", 32'(o_pix_ready), 0);
        chk("rst_err0", 32'(o_err), 0);
        chk("rst_wdata_pass", 32'(o_w_data), 32'h1234);
        tick();
        rst = 1'b0;
        tick();

        // 1: normal frame
        normal_frame();

        // 2: backpressure with alternating tvalid and random pix_req
        w0 = wr_cnt; r0 = rd_cnt;
        start_frame();
        nw = 0;
        for (int c = 0; c < 40 && nw < 3; c++) begin
            if (c % 2 == 0) begin
                i_wm_tvalid = 1'b1;
                i_wm_tdata = W'($urandom);
                i_wm_cnt_last = (nw == 2);
                wq.push_back(i_wm_tdata);
                nw++;
            end else begin
                i_wm_tvalid = 1'b0;
                i_wm_cnt_last = 1'b0;
            end
            tick();
        end
        i_wm_tvalid = 1'b0; i_wm_cnt_last = 1'b0;
        chk("bp_writes", 32'(wr_cnt - w0), 3);
        ns = 0;
        for (int c = 0; c < 100 && ns < 12; c++) begin
            i_pix_req = 1'($urandom_range(0, 1));
            if (i_pix_req) ns++;
            #1;
            chk("bp_rea", 32'(o_rea), 32'(i_pix_req));
            tick();
        end
        i_pix_req = 1'b0;
        #1;
        chk("bp_done", 32'(o_done), 1);
        tick();
        chk("bp_busy_off", 32'(o_busy), 0);
        chk("bp_reads", 32'(rd_cnt - r0), 12);
        chk("bp_err", 32'(o_err), 0);

        // 3: abort during LOAD after the first word
        d0 = done_cnt; w0 = wr_cnt;
        start_frame();
        load_word(16'hA5A5, 1'b0);
        i_abort = 1'b1; i_wm_tvalid = 1'b1; i_wm_tdata = 16'hBEEF;
        #1;
        chk("ab_load_tready", 32'(o_wm_tready), 0);
        chk("ab_load_wea", 32'(o_wea), 0);
        tick();
        i_abort = 1'b0; i_wm_tvalid = 1'b0;
        #1;
        chk("ab_load_done", 32'(o_done), 1);
        tick();
        chk("ab_load_idle", 32'(o_busy), 0);
        chk("ab_load_done_cnt", 32'(done_cnt - d0), 1);
        chk("ab_load_writes", 32'(wr_cnt - w0), 1);
        start_frame();
        for (int i = 0; i < 3; i++) load_word(W'($urandom), i == 2);
        #1;
        chk("ab_reload_embed", 32'(o_pix_ready), 1);

        // 4: abort in EMBED coincident with pix_req at sym_cnt=5
        r0 = rd_cnt;
        for (int i = 0; i < 5; i++) begin
            i_pix_req = 1'b1;
            tick();
        end
        i_abort = 1'b1;
        #1;
        chk("ab_emb_rea", 32'(o_rea), 0);
        chk("ab_emb_pix_ready", 32'(o_pix_ready), 0);
        tick();
        i_abort = 1'b0; i_pix_req = 1'b0;
        #1;
        chk("ab_emb_done", 32'(o_done), 1);
        tick();
        chk("ab_emb_idle", 32'(o_busy), 0);
        chk("ab_emb_reads", 32'(rd_cnt - r0), 5);
        chk("ab_emb_err", 32'(o_err), 0);
        normal_frame();

        // 5a: pix_req during LOAD
        start_frame();
        i_pix_req = 1'b1;
        #1;
        chk("err_a_rea", 32'(o_rea), 0);
        tick();
        i_pix_req = 1'b0;
        chk("err_a_set", 32'(o_err), 1);
        for (int i = 0; i < 3; i++) load_word(W'($urandom), i == 2);
        #1;
        chk("err_a_flow", 32'(o_pix_ready), 1);
        chk("err_a_sticky", 32'(o_err), 1);
        do_reset();

        // 5b: start while busy
        start_frame();
        chk("err_b_pre", 32'(o_err), 0);
        start_frame();
        chk("err_b_set", 32'(o_err), 1);
        chk("err_b_flow", 32'(o_wm_tready), 1);
        do_reset();

        // 5c: buffer last flag raised on the first word
        start_frame();
        load_word(16'h0F0F, 1'b1);
        chk("err_c_set", 32'(o_err), 1);
        chk("err_c_flow", 32'(o_wm_tready), 1);
        do_reset();

        // 6: asynchronous reset in EMBED at sym_cnt=7
        start_frame();
        for (int i = 0; i < 3; i++) load_word(W'($urandom), i == 2);
        for (int i = 0; i < 7; i++) begin
            i_pix_req = 1'b1;
            tick();
        end
        i_pix_req = 1'b0;
        d0 = done_cnt;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", 32'(o_busy), 0);
        chk("arst_pix_ready", 32'(o_pix_ready), 0);
        chk("arst_done", 32'(o_done), 0);
        chk("arst_tready", 32'(o_wm_tready), 0);
        tick();
        rst = 1'b0;
        tick();
        chk("arst_no_done", 32'(done_cnt - d0), 0);
        normal_frame();

        chk("sb_drained", 32'(wq.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
